// File: rtl/chart_seq_pkg.sv
// Shared types and constants for the note-chart sequencer: FSM state encoding,
// tempo select codes and counter widths.
package chart_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TEMPO_SLOW     = 2'd0,
        TEMPO_MED      = 2'd1,
        TEMPO_FAST     = 2'd2,
        TEMPO_FAST_ALT = 2'd3
    } tempo_e;

    localparam int STEP_W = 9;
    // Wide enough for the slowest real-hardware period (15M cycles)
    localparam int DIV_W  = 24;

endpackage

// File: rtl/chart_tempo_divider.sv
// Tempo divider: latches the step period on load, then counts while running and
// emits a one-cycle shift strobe on the last cycle of every step.
module chart_tempo_divider
    import chart_seq_pkg::*;
#(
    parameter int unsigned DIV_SLOW = 15000000,
    parameter int unsigned DIV_MED  = 6600000,
    parameter int unsigned DIV_FAST = 2400000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       run_i,
    input  logic [1:0] tempo_sel_i,
    output logic       shift_en_o
);

    logic [DIV_W-1:0] last_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] last_d;

    always_comb begin
        last_d = DIV_W'(DIV_FAST - 1);
        case (tempo_e'(tempo_sel_i))
            TEMPO_SLOW: last_d = DIV_W'(DIV_SLOW - 1);
            TEMPO_MED:  last_d = DIV_W'(DIV_MED - 1);
            default:    last_d = DIV_W'(DIV_FAST - 1);
        endcase
    end

    // Storing period-1 lets the strobe be a plain equality compare
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            last_q <= last_d;
            cnt_q  <= '0;
        end else if (run_i) begin
            cnt_q <= shift_en_o ? '0 : cnt_q + 1'b1;
        end
    end

    assign shift_en_o = run_i && (cnt_q == last_q);

endmodule

// File: rtl/note_chart_sequencer.sv
// Note-chart sequencer for one guitar lane: song FSM, button synchronizer, hit/miss
// judging and saturating score. Define CHART_STREAK_EN to enable streak tracking.
module note_chart_sequencer
    import chart_seq_pkg::*;
#(
    parameter int unsigned CHART_LEN = 320,
    parameter int unsigned DIV_SLOW  = 15000000,
    parameter int unsigned DIV_MED   = 6600000,
    parameter int unsigned DIV_FAST  = 2400000,
    parameter int          CNT_W     = 10
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        tempo_sel_i,
    input  logic              button_i,
    input  logic              hit_bit_i,
    output logic              chart_load_o,
    output logic              shift_en_o,
    output logic [STEP_W-1:0] step_count_o,
    output logic              hit_pulse_o,
    output logic              miss_pulse_o,
    output logic [CNT_W-1:0]  hit_count_o,
    output logic [CNT_W-1:0]  miss_count_o,
    output logic [CNT_W-1:0]  streak_o,
    output logic [CNT_W-1:0]  best_streak_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q;
    logic              start_prev_q;
    logic              btn_meta_q, btn_sync_q, btn_prev_q;
    logic              chart_load_q, hit_pulse_q, miss_pulse_q, judged_q;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              start_edge, btn_edge, shift_en, hit_now, miss_now;

    chart_tempo_divider #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_MED  (DIV_MED),
        .DIV_FAST (DIV_FAST)
    ) u_divider (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .load_i      (state_q == ST_LOAD),
        .run_i       (state_q == ST_PLAY),
        .tempo_sel_i (tempo_sel_i),
        .shift_en_o  (shift_en)
    );

    assign start_edge = start_i & ~start_prev_q;
    assign btn_edge   = btn_sync_q & ~btn_prev_q;

    // A press on the shift cycle is judged against the outgoing note and pre-empts its miss
    assign hit_now  = (state_q == ST_PLAY) & btn_edge & hit_bit_i & ~judged_q;
    assign miss_now = shift_en & hit_bit_i & ~judged_q & ~hit_now;

    assign step_d     = step_q + 1'b1;
    assign hit_cnt_d  = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
    assign miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            btn_meta_q   <= 1'b0;
            btn_sync_q   <= 1'b0;
            btn_prev_q   <= 1'b0;
            chart_load_q <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            judged_q     <= 1'b0;
            step_q       <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            start_prev_q <= start_i;
            btn_meta_q   <= button_i;
            btn_sync_q   <= btn_meta_q;
            btn_prev_q   <= btn_sync_q;
            chart_load_q <= 1'b0;
            hit_pulse_q  <= hit_now;
            miss_pulse_q <= miss_now;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        state_q      <= ST_LOAD;
                        chart_load_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q    <= ST_PLAY;
                    judged_q   <= 1'b0;
                    step_q     <= '0;
                    hit_cnt_q  <= '0;
                    miss_cnt_q <= '0;
                end
                ST_PLAY: begin
                    if (hit_now) begin
                        judged_q  <= 1'b1;
                        hit_cnt_q <= hit_cnt_d;
                    end
                    if (miss_now) begin
                        miss_cnt_q <= miss_cnt_d;
                    end
                    if (shift_en) begin
                        judged_q <= 1'b0;
                        step_q   <= step_d;
                        if (step_d == STEP_W'(CHART_LEN)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CHART_STREAK_EN
    logic [CNT_W-1:0] streak_q, streak_d, best_q;

    assign streak_d = (streak_q == '1) ? streak_q : streak_q + 1'b1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            streak_q <= '0;
            best_q   <= '0;
        end else if (state_q == ST_LOAD) begin
            streak_q <= '0;
            best_q   <= '0;
        end else if (hit_now) begin
            streak_q <= streak_d;
            if (streak_d > best_q) begin
                best_q <= streak_d;
            end
        end else if (miss_now) begin
            streak_q <= '0;
        end
    end

    assign streak_o      = streak_q;
    assign best_streak_o = best_q;
`else
    assign streak_o      = '0;
    assign best_streak_o = '0;
`endif

    assign chart_load_o = chart_load_q;
    assign shift_en_o   = shift_en;
    assign step_count_o = step_q;
    assign hit_pulse_o  = hit_pulse_q;
    assign miss_pulse_o = miss_pulse_q;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
    assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_PLAY);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Bench for note_chart_sequencer: directed and random songs against a cycle-level
// behavioural model of the song rules, plus hand-computed end-of-song scores.
module tb_note_chart_sequencer;

    localparam int LEN  = 8;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;
`ifdef CHART_STREAK_EN
    localparam bit STREAK_ON = 1'b1;
`else
    localparam bit STREAK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    tempo = 2'd0;
    logic          button = 1'b0;
    logic          hit_bit = 1'b0;
    logic          chart_load, shift_en, hit_pulse, miss_pulse, busy, done;
    logic [8:0]    step_count;
    logic [CW-1:0] hit_count, miss_count, streak, best_streak;

    always #5 clk = ~clk;

    note_chart_sequencer #(
        .CHART_LEN (LEN),
        .DIV_SLOW  (8),
        .DIV_MED   (4),
        .DIV_FAST  (2),
        .CNT_W     (CW)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .start_i       (start),
        .tempo_sel_i   (tempo),
        .button_i      (button),
        .hit_bit_i     (hit_bit),
        .chart_load_o  (chart_load),
        .shift_en_o    (shift_en),
        .step_count_o  (step_count),
        .hit_pulse_o   (hit_pulse),
        .miss_pulse_o  (miss_pulse),
        .hit_count_o   (hit_count),
        .miss_count_o  (miss_count),
        .streak_o      (streak),
        .best_streak_o (best_streak),
        .busy_o        (busy),
        .done_o        (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int sel);
        if (sel == 0) return 8;
        if (sel == 1) return 4;
        return 2;
    endfunction

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    // Model: mode 0 idle, 1 load, 2 play, 3 done; pc = cycles spent in play this song
    int m_mode = 0, m_period = 1, m_pc = 0, m_step = 0;
    int m_hits = 0, m_misses = 0, m_streak = 0, m_best = 0;
    bit m_hp = 0, m_mp = 0, m_judged = 0, m_sprev = 0;
    bit [2:0] m_bh = 3'b000;

    always @(posedge clk or posedge rst) begin
        bit s_edge, b_edge, sh, hit, miss;
        if (rst) begin
            m_mode = 0; m_period = 1; m_pc = 0; m_step = 0;
            m_hits = 0; m_misses = 0; m_streak = 0; m_best = 0;
            m_hp = 0; m_mp = 0; m_judged = 0; m_sprev = 0; m_bh = 3'b000;
        end else begin
            s_edge  = start && !m_sprev;
            m_sprev = start;
            // button seen through two sync stages; an edge is a 0->1 step of the synced level
            b_edge  = m_bh[1] && !m_bh[2];
            m_bh    = {m_bh[1:0], button};
            m_hp = 0;
            m_mp = 0;
            case (m_mode)
                0, 3: if (s_edge) m_mode = 1;
                1: begin
                    m_period = period_of(int'(tempo));
                    m_pc = 0; m_step = 0; m_judged = 0;
                    m_hits = 0; m_misses = 0; m_streak = 0; m_best = 0;
                    m_mode = 2;
                end
                default: begin
                    sh   = (m_pc % m_period) == m_period - 1;
                    hit  = b_edge && hit_bit && !m_judged;
                    miss = sh && hit_bit && !m_judged && !hit;
                    if (hit) begin
                        m_hits = sat(m_hits + 1);
                        m_streak = sat(m_streak + 1);
                        if (m_streak > m_best) m_best = m_streak;
                        m_hp = 1;
                        m_judged = 1;
                    end
                    if (miss) begin
                        m_misses = sat(m_misses + 1);
                        m_streak = 0;
                        m_mp = 1;
                    end
                    if (sh) begin
                        m_judged = 0;
                        m_step++;
                        if (m_step == LEN) m_mode = 3;
                    end
                    m_pc++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("chart_load", chart_load, m_mode == 1);
        chk("shift_en", shift_en, (m_mode == 2) && ((m_pc % m_period) == m_period - 1));
        chk("step_count", step_count, m_step);
        chk("hit_pulse", hit_pulse, m_hp);
        chk("miss_pulse", miss_pulse, m_mp);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
        chk("streak", streak, STREAK_ON ? m_streak : 0);
        chk("best_streak", best_streak, STREAK_ON ? m_best : 0);
        chk("busy", busy, (m_mode == 1) || (m_mode == 2));
        chk("done", done, m_mode == 3);
    end

    int press_a[LEN];
    int press_b[LEN];

    task automatic clear_presses();
        for (int k = 0; k < LEN; k++) begin
            press_a[k] = -1;
            press_b[k] = -1;
        end
    endtask

    // Cycle 0 raises start; LOAD is cycle 1; step k spans cycles 2+k*p .. 1+(k+1)*p.
    // A press with offset o yields a synced edge at cycle 2+k*p+o (button high two cycles earlier).
    task automatic run_song(input string tag, input int tsel, input logic [7:0] chart,
                            input int abort_at);
        int p, total, pc, e;
        bit btn;
        p = period_of(tsel);
        total = 2 + LEN * p + 3;
        if (abort_at >= 0) total = abort_at + 4;
        for (int c = 0; c < total; c++) begin
            @(posedge clk);
            #1;
            pc = c - 2;
            if (c == 0) start = 1'b1;
            else if (abort_at >= 0 && c >= abort_at) start = 1'b0;
            else if (c >= 2 && c <= 1 + LEN * p) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
            tempo = (c <= 1) ? 2'(tsel) : 2'($urandom_range(0, 3));
            if (pc >= 0 && pc < LEN * p) hit_bit = chart[pc / p];
            else hit_bit = 1'($urandom_range(0, 1));
            btn = 1'b0;
            for (int k = 0; k < LEN; k++) begin
                e = 2 + k * p + press_a[k];
                if (press_a[k] >= 0 && (c == e - 2 || c == e - 1)) btn = 1'b1;
                e = 2 + k * p + press_b[k];
                if (press_b[k] >= 0 && (c == e - 2 || c == e - 1)) btn = 1'b1;
            end
            button = btn;
            rst = (abort_at >= 0 && (c == abort_at || c == abort_at + 1));
            if (c == 1 || c == 1 + p || (abort_at >= 0 && c == abort_at)) begin
                @(negedge clk);
                if (c == 1) chk("load_pulse_lit", chart_load, 1);
                if (c == 1 + p && abort_at < 0) chk("first_shift_lit", shift_en, 1);
                if (abort_at >= 0 && c == abort_at) begin
                    chk("abort_busy_lit", busy, 0);
                    chk("abort_step_lit", step_count, 0);
                    chk("abort_hits_lit", hit_count, 0);
                end
            end
        end
        @(negedge clk);
        $display("song %s tempo=%0d chart=%08b step=%0d hits=%0d misses=%0d streak=%0d best=%0d done=%0d",
                 tag, tsel, chart, step_count, hit_count, miss_count, streak, best_streak, done);
    endtask

    initial begin
        int tsel, p;
        clear_presses();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy_lit", busy, 0);
        chk("reset_done_lit", done, 0);

        // Four notes, each pressed once mid-step
        for (int k = 0; k < 4; k++) press_a[k] = 1;
        run_song("A", 1, 8'b0000_1111, -1);
        chk("A_done_lit", done, 1);
        chk("A_busy_lit", busy, 0);
        chk("A_step_lit", step_count, LEN);
        chk("A_hits_lit", hit_count, 4);
        chk("A_miss_lit", miss_count, 0);
        chk("A_streak_lit", streak, STREAK_ON ? 4 : 0);
        chk("A_best_lit", best_streak, STREAK_ON ? 4 : 0);
        chk("A_model_hits_lit", m_hits, 4);

        // Single unplayed note on step 2, restarted from DONE
        clear_presses();
        run_song("B", 2, 8'b0000_0100, -1);
        chk("B_hits_lit", hit_count, 0);
        chk("B_miss_lit", miss_count, 1);
        chk("B_streak_lit", streak, 0);
        chk("B_model_miss_lit", m_misses, 1);

        // Double press on a note, press on an empty step, press landing on the shift cycle
        clear_presses();
        press_a[0] = 1;
        press_b[0] = 5;
        press_a[1] = 2;
        press_a[3] = 7;
        run_song("C", 0, 8'b0000_1001, -1);
        chk("C_hits_lit", hit_count, 2);
        chk("C_miss_lit", miss_count, 0);
        chk("C_best_lit", best_streak, STREAK_ON ? 2 : 0);

        // Reset part-way through a song
        clear_presses();
        press_a[1] = 0;
        run_song("D_abort", 1, 8'b1111_1111, 12);

        for (int s = 0; s < 12; s++) begin
            tsel = int'($urandom_range(0, 3));
            p = period_of(tsel);
            for (int k = 0; k < LEN; k++) begin
                press_a[k] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, p - 1));
                press_b[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, p - 1)) : -1;
            end
            run_song($sformatf("R%0d", s), tsel, 8'($urandom_range(0, 255)), -1);
            chk("R_done", done, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
